// File: rtl/team_06_wb_pkg.sv
// Shared Wishbone types and helpers for the team_06 manager/responder pair.
package team_06_wb_pkg;

  typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_ACK} wb_state_t;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  // Lane i of the result comes from new_word when sel[i] is set, else from old_word.
  function automatic logic [WB_DW-1:0] wb_byte_merge(input logic [WB_DW-1:0]   old_word,
                                                     input logic [WB_DW-1:0]   new_word,
                                                     input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WB_SELW; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/team_06_wb_sram_responder_if.sv
// Wishbone classic (B4) bus bundle between the team_06 manager and its SRAM responder.
interface team_06_wb_sram_responder_if;
  import team_06_wb_pkg::*;

  // Handshake: a request is valid while CYC_I & STB_I; the responder completes it
  // with a single-cycle ACK_O (DAT_O/OOR_O valid only in that cycle). Dropping CYC_I
  // before ACK_O abandons the request with no side effects.
  logic               CYC_I;
  logic               STB_I;
  logic               WE_I;
  logic [31:0]        ADR_I;
  logic [WB_SELW-1:0] SEL_I;
  logic [WB_DW-1:0]   DAT_I;
  logic [WB_DW-1:0]   DAT_O;
  logic               ACK_O;
  logic               OOR_O;

  modport master (output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                  input  DAT_O, ACK_O, OOR_O);
  modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                  output DAT_O, ACK_O, OOR_O);
endinterface

// File: rtl/team_06_wb_mem_array.sv
// Single-port word array with byte-lane writes and a registered read port.
module team_06_wb_mem_array
  import team_06_wb_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WB_SELW-1:0]       wr_be,
  input  logic [WB_DW-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WB_DW-1:0]         rdata
);

  logic [WB_DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it maps onto the SRAM macro later.
  always_ff @(posedge clk) begin
    if (|wr_be) mem[addr] <= wb_byte_merge(mem[addr], wdata, wr_be);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/team_06_wb_sram_responder.sv
// Wishbone classic subordinate backed by a word array, with wait states and range decode.
module team_06_wb_sram_responder
  import team_06_wb_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] OOR_RDATA   = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         nRST,
  team_06_wb_sram_responder_if.slave   bus,
  output wb_state_t                    dbg_state
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t          state;
  logic [3:0]         wait_cnt;
  logic [AW-1:0]      lat_idx;
  logic               lat_we;
  logic [WB_SELW-1:0] lat_sel;
  logic [WB_DW-1:0]   lat_dat;
  logic               lat_inr;
  logic               ack_q;
  logic               oor_q;
  logic               oor_rd_q;

  logic [31:0]        offset;
  logic               req;
  logic               req_inr;
  logic               from_idle;
  logic               go_ack;
  logic [AW-1:0]      c_idx;
  logic               c_we;
  logic [WB_SELW-1:0] c_sel;
  logic [WB_DW-1:0]   c_dat;
  logic               c_inr;
  logic [WB_SELW-1:0] mem_wr_be;
  logic               mem_rd_en;
  logic [WB_DW-1:0]   mem_rdata;

  // Unsigned wrap makes addresses below BASE_ADDR decode as out of range too.
  assign offset    = bus.ADR_I - BASE_ADDR;
  assign req       = bus.CYC_I & bus.STB_I;
  assign req_inr   = offset < SPAN;
  assign from_idle = (state == WB_IDLE);

  assign go_ack = (from_idle && req && (WAIT_STATES == 0)) ||
                  ((state == WB_WAIT) && bus.CYC_I && (wait_cnt == 4'd0));

  // With zero wait states the access happens on the accepting edge, before anything is latched.
  assign c_idx = from_idle ? offset[AW+1:2] : lat_idx;
  assign c_we  = from_idle ? bus.WE_I       : lat_we;
  assign c_sel = from_idle ? bus.SEL_I      : lat_sel;
  assign c_dat = from_idle ? bus.DAT_I      : lat_dat;
  assign c_inr = from_idle ? req_inr        : lat_inr;

  assign mem_wr_be = (go_ack && nRST && c_we && c_inr) ? c_sel : '0;
  assign mem_rd_en = go_ack && nRST && !c_we && c_inr;

  team_06_wb_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (nRST),
    .addr  (c_idx),
    .wr_be (mem_wr_be),
    .wdata (c_dat),
    .rd_en (mem_rd_en),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= WB_IDLE;
      wait_cnt <= 4'd0;
      lat_idx  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_dat  <= '0;
      lat_inr  <= 1'b0;
      ack_q    <= 1'b0;
      oor_q    <= 1'b0;
      oor_rd_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      oor_q <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (req) begin
            lat_idx <= offset[AW+1:2];
            lat_we  <= bus.WE_I;
            lat_sel <= bus.SEL_I;
            lat_dat <= bus.DAT_I;
            lat_inr <= req_inr;
            if (WAIT_STATES == 0) begin
              state <= WB_ACK;
            end else begin
              state    <= WB_WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
        end
        WB_WAIT: begin
          if (!bus.CYC_I)             state    <= WB_IDLE;
          else if (wait_cnt == 4'd0)  state    <= WB_ACK;
          else                        wait_cnt <= wait_cnt - 4'd1;
        end
        WB_ACK:  state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase
      if (go_ack) begin
        ack_q <= 1'b1;
        oor_q <= !c_inr;
        if (!c_we) oor_rd_q <= !c_inr;
      end
    end
  end

  // DAT_O only changes on read acks: oor_rd_q and mem_rdata both hold otherwise.
  assign bus.DAT_O = oor_rd_q ? OOR_RDATA : mem_rdata;
  assign bus.ACK_O = ack_q;
  assign bus.OOR_O = oor_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_team_06_wb_sram_responder.sv
// Directed bench for team_06_wb_sram_responder at WAIT_STATES 0, 1 and 3.
module tb_team_06_wb_sram_responder;
  import team_06_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3300_0000;
  localparam logic [31:0] OOR1 = 32'hDEAD_BEEF;

  logic clk;
  logic nRST;
  logic cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  int          tgt;

  logic        ack_m, oor_m;
  logic [31:0] dat_m;
  wb_state_t   st0, st1, st3;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];
  logic        exp_oor_q[$];

  team_06_wb_sram_responder_if bus0();
  team_06_wb_sram_responder_if bus1();
  team_06_wb_sram_responder_if bus3();

  assign bus0.CYC_I = cyc && (tgt == 0);
  assign bus0.STB_I = stb && (tgt == 0);
  assign bus0.WE_I  = we;
  assign bus0.ADR_I = adr;
  assign bus0.SEL_I = sel;
  assign bus0.DAT_I = dat;
  assign bus1.CYC_I = cyc && (tgt == 1);
  assign bus1.STB_I = stb && (tgt == 1);
  assign bus1.WE_I  = we;
  assign bus1.ADR_I = adr;
  assign bus1.SEL_I = sel;
  assign bus1.DAT_I = dat;
  assign bus3.CYC_I = cyc && (tgt == 3);
  assign bus3.STB_I = stb && (tgt == 3);
  assign bus3.WE_I  = we;
  assign bus3.ADR_I = adr;
  assign bus3.SEL_I = sel;
  assign bus3.DAT_I = dat;

  team_06_wb_sram_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .nRST(nRST), .bus(bus0), .dbg_state(st0));
  team_06_wb_sram_responder #(.WAIT_STATES(1), .OOR_RDATA(OOR1)) u_ws1 (
    .clk(clk), .nRST(nRST), .bus(bus1), .dbg_state(st1));
  team_06_wb_sram_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .nRST(nRST), .bus(bus3), .dbg_state(st3));

  always_comb begin
    ack_m = bus3.ACK_O;
    oor_m = bus3.OOR_O;
    dat_m = bus3.DAT_O;
    if (tgt == 0) begin
      ack_m = bus0.ACK_O; oor_m = bus0.OOR_O; dat_m = bus0.DAT_O;
    end else if (tgt == 1) begin
      ack_m = bus1.ACK_O; oor_m = bus1.OOR_O; dat_m = bus1.DAT_O;
    end
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, waits for ACK, scores latency/OOR/data and the single-cycle ACK.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_oor);
    int n;
    logic [31:0] e;
    logic eo;
    if (!w) exp_q.push_back(exp_rd);
    exp_oor_q.push_back(exp_oor);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_m && n < 20);
    check({tag, " latency"}, 32'(n), 32'(tgt + 1));
    eo = exp_oor_q.pop_front();
    check({tag, " oor"}, 32'(oor_m), 32'(eo));
    if (!w) begin
      e = exp_q.pop_front();
      check({tag, " data"}, dat_m, e);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack width"}, 32'(ack_m), 32'd0);
  endtask

  initial begin
    int seen;
    int k;
    int n;
    logic [31:0] b2b_vals [4];
    b2b_vals = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    n_checks = 0;
    n_fail   = 0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    tgt  = 1;
    nRST = 1'b0;

    // Reset and idle bus
    repeat (3) @(posedge clk);
    #1;
    check("rst ack", 32'(bus1.ACK_O), 32'd0);
    check("rst state", 32'(st1), 32'(WB_IDLE));
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle ack", 32'(bus1.ACK_O | bus0.ACK_O | bus3.ACK_O), 32'd0);
      check("idle dat", bus1.DAT_O, 32'd0);
      check("idle oor", 32'(bus1.OOR_O), 32'd0);
    end

    // One wait state: full word, byte lanes, SEL ignored on reads, empty-SEL write
    xfer("wr8",  1'b1, BASE + 32'd8, 4'hF, 32'hCAFE_F00D, '0, 1'b0);
    xfer("rd8",  1'b0, BASE + 32'd8, 4'hF, '0, 32'hCAFE_F00D, 1'b0);
    xfer("wr4a", 1'b1, BASE + 32'd4, 4'hF, 32'h1122_3344, '0, 1'b0);
    xfer("wr4b", 1'b1, BASE + 32'd4, 4'b0101, 32'hAABB_CCDD, '0, 1'b0);
    xfer("rd4",  1'b0, BASE + 32'd4, 4'hF, '0, 32'h11BB_33DD, 1'b0);
    xfer("rd4s0", 1'b0, BASE + 32'd4, 4'h0, '0, 32'h11BB_33DD, 1'b0);
    xfer("wr8s0", 1'b1, BASE + 32'd8, 4'h0, 32'h0000_0000, '0, 1'b0);
    xfer("rd8b", 1'b0, BASE + 32'd8, 4'hF, '0, 32'hCAFE_F00D, 1'b0);

    // Out of range: above the window aliases word 0 if decode is wrong, below wraps
    xfer("wr0",   1'b1, BASE, 4'hF, 32'h5A5A_0001, '0, 1'b0);
    xfer("rdoor", 1'b0, BASE + 32'd1024, 4'hF, '0, OOR1, 1'b1);
    xfer("wroor", 1'b1, BASE + 32'd1024, 4'hF, 32'hFFFF_FFFF, '0, 1'b1);
    check("dat hold", dat_m, OOR1);
    xfer("rdlow", 1'b0, BASE - 32'd4, 4'hF, '0, OOR1, 1'b1);
    xfer("rd0",   1'b0, BASE, 4'hF, '0, 32'h5A5A_0001, 1'b0);

    // Three wait states: abort by dropping CYC_I
    tgt = 3;
    xfer("wr12", 1'b1, BASE + 32'd12, 4'hF, 32'h1111_1111, '0, 1'b0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'd12; sel = 4'hF; dat = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack_m) seen = 1;
    end
    check("abort no ack", 32'(seen), 32'd0);
    check("abort state", 32'(st3), 32'(WB_IDLE));
    xfer("rd12", 1'b0, BASE + 32'd12, 4'hF, '0, 32'h1111_1111, 1'b0);

    // Reset while a write is waiting
    xfer("wr16", 1'b1, BASE + 32'd16, 4'hF, 32'h0000_00AA, '0, 1'b0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'd16; sel = 4'hF; dat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #2;
    nRST = 1'b0;
    #1;
    check("midrst ack", 32'(ack_m), 32'd0);
    check("midrst state", 32'(st3), 32'(WB_IDLE));
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    xfer("rd16", 1'b0, BASE + 32'd16, 4'hF, '0, 32'h0000_00AA, 1'b0);

    // Zero wait states: back-to-back reads with CYC/STB held
    tgt = 0;
    for (int i = 0; i < 4; i++)
      xfer("b2b wr", 1'b1, BASE + 32'h20 + 32'(4 * i), 4'hF, b2b_vals[i], '0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(b2b_vals[i]);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20; sel = 4'hF;
    k = 0;
    n = 0;
    while (k < 4 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack_m) begin
        check("b2b data", dat_m, exp_q.pop_front());
        check("b2b ack edge", 32'(n), 32'(2 * k + 1));
        k++;
        adr = BASE + 32'h20 + 32'(4 * k);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("b2b ack count", 32'(k), 32'd4);
    @(posedge clk); #1;
    n++;
    check("b2b total cycles", 32'(n), 32'd8);
    check("b2b final ack", 32'(ack_m), 32'd0);
    check("scoreboard empty", 32'(exp_q.size() + exp_oor_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
